keypad_entry_controller: RTL and testbench

Sequences key events from the keypad scanner into a 4-digit hex entry buffer and handles CLEAR/ENTER keys. It presents the completed 16-bit value over a valid/ready handshake. It also time-multiplexes the four-digit seven-segment display, driving the shared ssd_driver code input and the anode selects. It sits between the scanner/encoder (key_valid, key_code) and the system consumer plus the display.

---
 rtl/keypad_pkg.sv | 54 +++++
 rtl/keypad_entry_controller_display_mux.sv | 73 +++++++
 rtl/keypad_entry_controller.sv | 158 +++++++++++++++
 tb/tb_keypad_entry_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry controller: FSM encoding, default key codes
// and small display helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DEBOUNCE_S = 2'd1,
    ACCEPT     = 2'd2,
    RELEASE    = 2'd3
  } state_t;

  localparam logic [3:0] CLEAR_CODE_DEFAULT = 4'hE;
  localparam logic [3:0] ENTER_CODE_DEFAULT = 4'hF;
  localparam int         DIGITS             = 4;
  localparam logic [3:0] AN_RESET           = 4'b1110;

  function automatic logic [3:0] nibble_at(input logic [15:0] value, input logic [1:0] index);
    logic [3:0] nib;
    case (index)
      2'd0:    nib = value[3:0];
      2'd1:    nib = value[7:4];
      2'd2:    nib = value[11:8];
      2'd3:    nib = value[15:12];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  function automatic logic [3:0] anode_for(input logic [1:0] index);
    logic [3:0] an;
    case (index)
      2'd0:    an = 4'b1110;
      2'd1:    an = 4'b1101;
      2'd2:    an = 4'b1011;
      2'd3:    an = 4'b0111;
      default: an = 4'b1110;
    endcase
    return an;
  endfunction

  // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows.
  function automatic logic leading_zero(input logic [15:0] value, input logic [1:0] index);
    logic lz;
    case (index)
      2'd0:    lz = 1'b0;
      2'd1:    lz = (value[15:4] == 12'h000);
      2'd2:    lz = (value[15:8] == 8'h00);
      2'd3:    lz = (value[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase
    return lz;
  endfunction

endpackage

// File: rtl/keypad_entry_controller_display_mux.sv
// Four-digit display multiplexer: refresh timer, digit index and registered AN/digit_code.
// Optional KEYPAD_LEADING_ZERO_BLANK_EN adds the registered blank output.
module display_mux
  import keypad_pkg::*;
#(
  parameter int REFRESH_DIV = 8
) (
  input  logic        clock_new,
  input  logic        reset,
  input  logic [15:0] buffer,
  output logic [3:0]  digit_code,
  output logic [3:0]  AN
`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
  ,
  output logic        blank
`endif
);

  localparam int            RW           = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  logic [RW-1:0] refresh_r;
  logic [1:0]    index_r;
  logic [3:0]    an_r;
  logic [3:0]    code_r;
  logic          wrap_s;

  assign wrap_s = (refresh_r == REFRESH_LAST);

  // Refresh timer; the digit index steps on every wrap
  always_ff @(posedge clock_new or posedge reset) begin
    if (reset) begin
      refresh_r <= '0;
      index_r   <= 2'd0;
    end else if (wrap_s) begin
      refresh_r <= '0;
      index_r   <= index_r + 2'd1;
    end else begin
      refresh_r <= refresh_r + RW'(1);
      index_r   <= index_r;
    end
  end

  // Anode and code registered from the same index so they always switch together
  always_ff @(posedge clock_new or posedge reset) begin
    if (reset) begin
      an_r   <= AN_RESET;
      code_r <= 4'h0;
    end else begin
      an_r   <= anode_for(index_r);
      code_r <= nibble_at(buffer, index_r);
    end
  end

  assign AN         = an_r;
  assign digit_code = code_r;

`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
  logic blank_r;

  // Blank flag tracks the lit digit with the same one-cycle lag as AN
  always_ff @(posedge clock_new or posedge reset) begin
    if (reset) begin
      blank_r <= 1'b0;
    end else begin
      blank_r <= leading_zero(buffer, index_r);
    end
  end

  assign blank = blank_r;
`endif

endmodule

// File: rtl/keypad_entry_controller.sv
// Keypad entry controller: debounced key sequencing into a 4-digit hex buffer, CLEAR/ENTER
// handling, valid/ready entry output and display multiplexing. Option: KEYPAD_LEADING_ZERO_BLANK_EN.
module keypad_entry_controller
  import keypad_pkg::*;
#(
  parameter int         DEBOUNCE    = 4,
  parameter int         REFRESH_DIV = 8,
  parameter logic [3:0] CLEAR_CODE  = CLEAR_CODE_DEFAULT,
  parameter logic [3:0] ENTER_CODE  = ENTER_CODE_DEFAULT
) (
  input  logic        clock_new,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        entry_ready,
  output logic        entry_valid,
  output logic [15:0] entry_value,
  output logic [3:0]  digit_code,
  output logic [3:0]  AN
`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
  ,
  output logic        blank
`endif
);

  localparam int            CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);

  state_t        state_r, state_next_s;
  logic [CW-1:0] count_r, count_next_s;
  logic [3:0]    latch_r, latch_next_s;
  logic [15:0]   buffer_r;
  logic          entry_valid_r;
  logic [15:0]   entry_value_r;
  logic          do_clear_s, do_enter_s, do_shift_s;

  // FSM state, stability counter and latched key
  always_ff @(posedge clock_new or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      count_r <= '0;
      latch_r <= 4'h0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      latch_r <= latch_next_s;
    end
  end

  // Next-state logic; a press fires once, then waits for release (no auto-repeat)
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    latch_next_s = latch_r;
    case (state_r)
      IDLE: begin
        if (key_valid) begin
          latch_next_s = key_code;
          count_next_s = CW'(1);
          state_next_s = (DEBOUNCE <= 1) ? ACCEPT : DEBOUNCE_S;
        end else begin
          state_next_s = IDLE;
        end
      end
      DEBOUNCE_S: begin
        if (!key_valid || (key_code != latch_r)) begin
          count_next_s = '0;
          state_next_s = IDLE;
        end else if (count_r == DEB_LAST) begin
          count_next_s = count_r + CW'(1);
          state_next_s = ACCEPT;
        end else begin
          count_next_s = count_r + CW'(1);
          state_next_s = DEBOUNCE_S;
        end
      end
      ACCEPT: begin
        count_next_s = '0;
        state_next_s = RELEASE;
      end
      RELEASE: begin
        if (!key_valid) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RELEASE;
        end
      end
      default: begin
        count_next_s = '0;
        state_next_s = IDLE;
      end
    endcase
  end

  // Key action decode; ENTER is dropped whenever an entry is still pending (incl. same-cycle transfer)
  always_comb begin
    do_clear_s = 1'b0;
    do_enter_s = 1'b0;
    do_shift_s = 1'b0;
    if (state_r == ACCEPT) begin
      if (latch_r == CLEAR_CODE) begin
        do_clear_s = 1'b1;
      end else if (latch_r == ENTER_CODE) begin
        do_enter_s = !entry_valid_r;
      end else begin
        do_shift_s = 1'b1;
      end
    end else begin
      do_clear_s = 1'b0;
      do_enter_s = 1'b0;
      do_shift_s = 1'b0;
    end
  end

  // Entry buffer and the valid/ready output holding register
  always_ff @(posedge clock_new or posedge reset) begin
    if (reset) begin
      buffer_r      <= 16'h0000;
      entry_valid_r <= 1'b0;
      entry_value_r <= 16'h0000;
    end else begin
      if (do_enter_s) begin
        entry_value_r <= buffer_r;
        entry_valid_r <= 1'b1;
      end else if (entry_valid_r && entry_ready) begin
        entry_valid_r <= 1'b0;
      end else begin
        entry_valid_r <= entry_valid_r;
      end

      if (do_clear_s || do_enter_s) begin
        buffer_r <= 16'h0000;
      end else if (do_shift_s) begin
        buffer_r <= {buffer_r[11:0], latch_r};
      end else begin
        buffer_r <= buffer_r;
      end
    end
  end

  assign entry_valid = entry_valid_r;
  assign entry_value = entry_value_r;

  display_mux #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_display_mux (
    .clock_new  (clock_new),
    .reset      (reset),
    .buffer     (buffer_r),
    .digit_code (digit_code),
    .AN         (AN)
`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
    ,
    .blank      (blank)
`endif
  );

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Self-checking bench for keypad_entry_controller: table of key presses plus hand sequences
// for handshake, display scan and reset corner cases; entry values checked via a scoreboard queue.
module tb_keypad_entry_controller;

  localparam int DEB  = 4;
  localparam int RDIV = 2;

  logic        clock_new = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        entry_ready;
  logic        entry_valid;
  logic [15:0] entry_value;
  logic [3:0]  digit_code;
  logic [3:0]  AN;
`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
  logic        blank;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  keypad_entry_controller #(
    .DEBOUNCE    (DEB),
    .REFRESH_DIV (RDIV)
  ) dut (
    .clock_new   (clock_new),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .entry_ready (entry_ready),
    .entry_valid (entry_valid),
    .entry_value (entry_value),
    .digit_code  (digit_code),
    .AN          (AN)
`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
    ,
    .blank       (blank)
`endif
  );

  always #5 clock_new = ~clock_new;

  typedef struct {
    logic [3:0]  code;
    int          hold;
    logic [15:0] exp_buf;
    logic        exp_valid;
    logic        push;
    logic [15:0] push_val;
  } vec_t;

  vec_t vecs[20];

  // Scoreboard: a transfer happens at the next rising edge whenever valid & ready are both high
  always @(negedge clock_new) begin
    if (!reset && entry_valid && entry_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL xfer_unexpected: got entry_value=%h, expected no transfer", entry_value);
      end else begin
        mon_exp = exp_q.pop_front();
        if (entry_value !== mon_exp) begin
          n_err++;
          $display("FAIL xfer_value: got %h expected %h", entry_value, mon_exp);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock_new);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold);
    key_valid = 1'b1;
    key_code  = code;
    repeat (hold) tick;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (3) tick;
  endtask

  // Reconstruct the displayed buffer (and blank flags) from one full refresh scan
  task automatic scan(output logic [15:0] value, output logic [3:0] blanks);
    logic [3:0] seen;
    logic [3:0] an_k;
    logic       hit;
    seen   = 4'h0;
    value  = 16'h0000;
    blanks = 4'h0;
    for (int i = 0; i < 4 * RDIV + 4; i++) begin
      hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
        an_k = 4'hF;
        an_k[k] = 1'b0;
        if (AN == an_k) begin
          hit = 1'b1;
          seen[k] = 1'b1;
          value[4*k +: 4] = digit_code;
`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
          blanks[k] = blank;
`endif
        end
      end
      if (!hit) begin
        n_vec++;
        n_err++;
        $display("FAIL an_onehot: got AN=%b, required exactly one low bit", AN);
      end
      tick;
    end
    check("scan_cover", {28'h0, seen}, 32'hF);
  endtask

  task automatic check_buf(input string name, input logic [15:0] exp);
    logic [15:0] v;
    logic [3:0]  b;
    scan(v, b);
    check(name, {16'h0, v}, {16'h0, exp});
  endtask

  logic [3:0]  an_seq[4];
  logic [3:0]  code_seq[4];
  logic [3:0]  prev_an;
  logic        found;
  logic [15:0] sv;
  logic [3:0]  sb;

  initial begin
    vecs[0]  = '{4'h3, 3,  16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{4'h3, 5,  16'h0003, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{4'hE, 4,  16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{4'h3, 50, 16'h0003, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{4'hE, 4,  16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{4'h1, 4,  16'h0001, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{4'h2, 4,  16'h0012, 1'b0, 1'b0, 16'h0000};
    vecs[7]  = '{4'h3, 4,  16'h0123, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{4'h4, 4,  16'h1234, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{4'h5, 4,  16'h2345, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{4'hE, 4,  16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{4'h1, 4,  16'h0001, 1'b0, 1'b0, 16'h0000};
    vecs[12] = '{4'h2, 4,  16'h0012, 1'b0, 1'b0, 16'h0000};
    vecs[13] = '{4'hF, 4,  16'h0000, 1'b1, 1'b1, 16'h0012};
    vecs[14] = '{4'h7, 4,  16'h0007, 1'b1, 1'b0, 16'h0000};
    vecs[15] = '{4'hF, 4,  16'h0007, 1'b1, 1'b0, 16'h0000};
    vecs[16] = '{4'h9, 2,  16'h0007, 1'b1, 1'b0, 16'h0000};
    vecs[17] = '{4'h6, 6,  16'h0076, 1'b1, 1'b0, 16'h0000};
    vecs[18] = '{4'hE, 4,  16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[19] = '{4'h7, 4,  16'h0007, 1'b1, 1'b0, 16'h0000};
    an_seq   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    code_seq = '{4'h3, 4'hC, 4'h5, 4'hA};

    reset       = 1'b1;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    entry_ready = 1'b0;
    #12;
    check("rst_an", {28'h0, AN}, 32'hE);
    check("rst_code", {28'h0, digit_code}, 32'h0);
    check("rst_valid", {31'h0, entry_valid}, 32'h0);
    check("rst_value", {16'h0, entry_value}, 32'h0);
    tick;
    reset = 1'b0;
    check_buf("rst_buf", 16'h0000);

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].push) exp_q.push_back(vecs[i].push_val);
      press(vecs[i].code, vecs[i].hold);
      check_buf($sformatf("vec%0d_buf", i), vecs[i].exp_buf);
      check($sformatf("vec%0d_valid", i), {31'h0, entry_valid}, {31'h0, vecs[i].exp_valid});
    end

    // Stalled entry drains once ready rises; valid falls right after that edge
    check("hs_value_held", {16'h0, entry_value}, 32'h0012);
    entry_ready = 1'b1;
    tick;
    entry_ready = 1'b0;
    check("hs_valid_fall", {31'h0, entry_valid}, 32'h0);

    // ENTER accepted on the same edge a transfer completes: ENTER dropped, buffer kept
    exp_q.push_back(16'h0007);
    press(4'hF, 4);
    check("enter2_valid", {31'h0, entry_valid}, 32'h1);
    press(4'h8, 4);
    key_valid = 1'b1;
    key_code  = 4'hF;
    repeat (DEB) tick;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    entry_ready = 1'b1;
    tick;
    entry_ready = 1'b0;
    check("same_cycle_valid", {31'h0, entry_valid}, 32'h0);
    tick;
    tick;
    check_buf("same_cycle_buf", 16'h0008);
    check("queue_drained", exp_q.size(), 32'h0);

    // Display sequence for A5C3
    press(4'hE, 4);
    press(4'hA, 4);
    press(4'h5, 4);
    press(4'hC, 4);
    press(4'h3, 4);
    scan(sv, sb);
    check("disp_buf", {16'h0, sv}, 32'hA5C3);
`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
    check("disp_blank", {28'h0, sb}, 32'h0);
`endif
    prev_an = AN;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick;
      if (prev_an == 4'b0111 && AN == 4'b1110) found = 1'b1;
      else prev_an = AN;
    end
    check("an_sync", {31'h0, found}, 32'h1);
    for (int k = 0; k < 4 * RDIV; k++) begin
      check($sformatf("an_seq%0d", k), {28'h0, AN}, {28'h0, an_seq[k / RDIV]});
      check($sformatf("code_seq%0d", k), {28'h0, digit_code}, {28'h0, code_seq[k / RDIV]});
      tick;
    end

`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
    press(4'hE, 4);
    press(4'h4, 4);
    press(4'h2, 4);
    scan(sv, sb);
    check("blank_buf", {16'h0, sv}, 32'h0042);
    check("blank_bits", {28'h0, sb}, 32'hC);
`endif

    // Asynchronous reset mid-debounce with a pending entry
    press(4'hE, 4);
    press(4'h6, 4);
    exp_q.push_back(16'h0006);
    press(4'hF, 4);
    check("pre_rst_valid", {31'h0, entry_valid}, 32'h1);
    key_valid = 1'b1;
    key_code  = 4'h5;
    tick;
    tick;
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", {31'h0, entry_valid}, 32'h0);
    check("arst_value", {16'h0, entry_value}, 32'h0);
    check("arst_an", {28'h0, AN}, 32'hE);
    check("arst_code", {28'h0, digit_code}, 32'h0);
`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
    check("arst_blank", {31'h0, blank}, 32'h0);
`endif
    exp_q.delete();
    tick;
    reset = 1'b0;
    repeat (DEB) tick;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (3) tick;
    check_buf("held_after_rst_buf", 16'h0005);
    check("held_after_rst_valid", {31'h0, entry_valid}, 32'h0);
    check("final_queue", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
